sc_stream_gen: RTL and testbench

- Stochastic number generator (SNG) feeding the stochastic add/multiply stage.
- Converts two unsigned binary operands into two unipolar stochastic bitstreams over one LFSR period.
- Each stream's ones-density equals operand/(2^WIDTH-1).
- Downstream consumes one bit pair per accepted beat via a valid/ready handshake, then receives a done pulse.

---
 rtl/sc_stream_gen.sv | 196 +++++++++++++++++++
 tb/tb_sc_stream_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_gen.sv
// ---------------------------------------------------------------------------
// sc_stream_gen -- stochastic number generator for the SC add/multiply stage.
//
// Converts two unsigned operands into two unipolar stochastic bitstreams over
// one full LFSR period (2^WIDTH-1 beats). Each stream carries exactly
// operand ones per window, because the maximal-length LFSR visits every
// nonzero value once and bit = (lfsr <= operand).
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      request a new window (only honoured in IDLE)
//   val_a/b    operands, latched on an accepted start
//   ready      downstream accepts the current bit pair
//   busy       high in RUN and DONE
//   bit_valid  bit_a/bit_b valid this cycle
//   bit_a/b    stochastic bits
//   done       one-cycle pulse after the final beat
//   ones_a/b   (only with SC_OUT_COUNT_EN) ones counted per window
//
// Optional feature macro: SC_OUT_COUNT_EN adds the ones_a/ones_b counters.
// ---------------------------------------------------------------------------
module sc_stream_gen #(
    parameter int          WIDTH  = 8,
    parameter logic [7:0]  SEED_A = 8'hA5,
    parameter logic [7:0]  SEED_B = 8'h3C
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] val_a,
    input  logic [WIDTH-1:0] val_b,
    input  logic             ready,
    output logic             busy,
    output logic             bit_valid,
    output logic             bit_a,
    output logic             bit_b,
`ifdef SC_OUT_COUNT_EN
    output logic [WIDTH-1:0] ones_a,
    output logic [WIDTH-1:0] ones_b,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_A_W = (SEED_A[WIDTH-1:0] == ZERO_W) ? ONE_W : SEED_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_B_W = (SEED_B[WIDTH-1:0] == ZERO_W) ? ONE_W : SEED_B[WIDTH-1:0];
    // Counter value on the last (2^WIDTH-1 th) beat of a window.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    // Fibonacci feedback: XOR of the maximal-length taps for this width.
    function automatic logic lfsr_fb(input logic [WIDTH-1:0] s);
        logic [7:0] e;
        e = 8'(s);
        case (WIDTH)
            32'd4:   lfsr_fb = e[3] ^ e[2];
            32'd5:   lfsr_fb = e[4] ^ e[2];
            32'd6:   lfsr_fb = e[5] ^ e[4];
            32'd7:   lfsr_fb = e[6] ^ e[5];
            default: lfsr_fb = e[7] ^ e[5] ^ e[4] ^ e[3];
        endcase
    endfunction

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        lfsr_step = {s[WIDTH-2:0], lfsr_fb(s)};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] va_q, va_d;
    logic [WIDTH-1:0] vb_q, vb_d;
    logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
    logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             cmp_a_s, cmp_b_s;

    assign cmp_a_s = (lfsr_a_q <= va_q);
    assign cmp_b_s = (lfsr_b_q <= vb_q);

    // Next-state and datapath update; everything holds unless a start is
    // accepted in IDLE or a beat occurs in RUN.
    always_comb begin
        state_d  = state_q;
        va_d     = va_q;
        vb_d     = vb_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    va_d     = val_a;
                    vb_d     = val_b;
                    lfsr_a_d = SEED_A_W;
                    lfsr_b_d = SEED_B_W;
                    cnt_d    = ZERO_W;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ready) begin
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                    cnt_d    = cnt_q + ONE_W;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            va_q     <= ZERO_W;
            vb_q     <= ZERO_W;
            lfsr_a_q <= SEED_A_W;
            lfsr_b_q <= SEED_B_W;
            cnt_q    <= ZERO_W;
        end else begin
            state_q  <= state_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are decoded straight from registers, so they stay stable while
    // the downstream stalls.
    assign busy      = (state_q != ST_IDLE);
    assign bit_valid = (state_q == ST_RUN);
    assign bit_a     = bit_valid & cmp_a_s;
    assign bit_b     = bit_valid & cmp_b_s;
    assign done      = (state_q == ST_DONE);

`ifdef SC_OUT_COUNT_EN
    logic [WIDTH-1:0] ones_a_q, ones_a_d;
    logic [WIDTH-1:0] ones_b_q, ones_b_d;

    // Ones counters: cleared on an accepted start, bumped on each beat,
    // otherwise held (so the final value persists after DONE).
    always_comb begin
        ones_a_d = ones_a_q;
        ones_b_d = ones_b_q;
        if ((state_q == ST_IDLE) && start) begin
            ones_a_d = ZERO_W;
            ones_b_d = ZERO_W;
        end else if (bit_valid && ready) begin
            ones_a_d = ones_a_q + {{(WIDTH-1){1'b0}}, bit_a};
            ones_b_d = ones_b_q + {{(WIDTH-1){1'b0}}, bit_b};
        end else begin
            ones_a_d = ones_a_q;
            ones_b_d = ones_b_q;
        end
    end

    // Ones counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_a_q <= ZERO_W;
            ones_b_q <= ZERO_W;
        end else begin
            ones_a_q <= ones_a_d;
            ones_b_q <= ones_b_d;
        end
    end

    assign ones_a = ones_a_q;
    assign ones_b = ones_b_q;
`endif

endmodule

// File: tb/tb_sc_stream_gen.sv
module tb_sc_stream_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] val_a;
    logic [7:0] val_b;
    logic       ready;
    logic       busy;
    logic       bit_valid;
    logic       bit_a;
    logic       bit_b;
    logic       done;
`ifdef SC_OUT_COUNT_EN
    logic [7:0] ones_a;
    logic [7:0] ones_b;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ea;
        int eb;
        int ecyc;
    } exp_t;

    exp_t exp_q[$];

    sc_stream_gen #(.WIDTH(8), .SEED_A(8'hA5), .SEED_B(8'h3C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .val_a     (val_a),
        .val_b     (val_b),
        .ready     (ready),
        .busy      (busy),
        .bit_valid (bit_valid),
        .bit_a     (bit_a),
        .bit_b     (bit_b),
`ifdef SC_OUT_COUNT_EN
        .ones_a    (ones_a),
        .ones_b    (ones_b),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor / scoreboard: accumulates each window and compares at done.
    int  acc_a, acc_b, beats, vcyc;
    bit  hold_prev, beat_prev;
    logic held_a, held_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_a = 0; acc_b = 0; beats = 0; vcyc = 0;
            hold_prev = 1'b0; beat_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid", int'(bit_valid), 1);
                check("stall_bits", int'({bit_a, bit_b}), int'({held_a, held_b}));
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ones_a", acc_a, e.ea);
                    check("ones_b", acc_b, e.eb);
                    check("beats", beats, 255);
                    check("valid_cycles", vcyc, e.ecyc);
                    check("done_after_last_beat", int'(beat_prev), 1);
                    check("done_busy", int'({busy, bit_valid}), 2);
`ifdef SC_OUT_COUNT_EN
                    check("cnt_ones_a", int'(ones_a), e.ea);
                    check("cnt_ones_b", int'(ones_b), e.eb);
`endif
                end
                acc_a = 0; acc_b = 0; beats = 0; vcyc = 0;
            end
            beat_prev = 1'b0;
            if (bit_valid) begin
                vcyc++;
                if (ready) begin
                    beats++;
                    acc_a += int'(bit_a);
                    acc_b += int'(bit_b);
                    beat_prev = 1'b1;
                end
            end
            hold_prev = bit_valid & ~ready;
            held_a = bit_a;
            held_b = bit_b;
        end
    end

    // mode 0: ready=1; 1: ready toggles; 2: start spam; 3: reset at beat 100
    task automatic run_window(input logic [7:0] a, input logic [7:0] b, input int mode);
        exp_t e;
        int   bt;
        bit   got_done;
        bt = 0;
        got_done = 1'b0;
        if (mode != 3) begin
            e.ea = int'(a);
            e.eb = int'(b);
            e.ecyc = (mode == 1) ? 509 : 255;
            exp_q.push_back(e);
        end
        val_a = a; val_b = b; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("first_valid_latency", int'({busy, bit_valid}), 3);
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (bit_valid && ready) bt++;
            @(posedge clk); #1;
            if (mode == 1) ready = ~ready;
            if (mode == 2) begin
                start = 1'b1;
                val_a = 8'($urandom);
                val_b = 8'($urandom);
            end
            if (mode == 3 && bt == 100) begin
                rst_n = 1'b0;
                #1;
                check("midrun_reset_outs", int'({busy, bit_valid, bit_a, bit_b, done}), 0);
                @(negedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("after_abort_idle", int'({busy, done}), 0);
                end
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        if (!got_done) check("done_timeout", 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_done", int'({busy, bit_valid, done}), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; val_a = 8'h00; val_b = 8'h00;
        #12;
        check("reset_outs", int'({busy, bit_valid, bit_a, bit_b, done}), 0);
`ifdef SC_OUT_COUNT_EN
        check("reset_counts", int'({ones_a, ones_b}), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_no_start", int'({busy, bit_valid, done}), 0);
        end

        run_window(8'h00, 8'hFF, 0);
        run_window(8'h80, 8'h40, 0);
`ifdef SC_OUT_COUNT_EN
        repeat (3) @(negedge clk);
        check("held_ones_a", int'(ones_a), 128);
        check("held_ones_b", int'(ones_b), 64);
`endif
        run_window(8'h80, 8'h40, 1);
        run_window(8'h33, 8'hCC, 2);
        run_window(8'h77, 8'h11, 3);
        run_window(8'h05, 8'hA0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
